// File: rtl/histeq_frame_seq_pkg.sv
// histeq_frame_seq_pkg: shared constants, state encoding and saturating add for the histogram-equalisation sequencer.
package histeq_frame_seq_pkg;
   localparam int HIST_BINS  = 256;
   localparam int HIST_CNT_W = 20;
   localparam int SCAN_LAST  = 257;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_SCAN,
      ST_CLEAR,
      ST_DONE
   } state_t;

   function automatic logic [HIST_CNT_W-1:0] sat_add(input logic [HIST_CNT_W-1:0] a,
                                                    input logic [HIST_CNT_W-1:0] b);
      logic [HIST_CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[HIST_CNT_W] ? '1 : s[HIST_CNT_W-1:0];
   endfunction
endpackage

// File: rtl/histeq_cdf_acc.sv
// histeq_cdf_acc: saturating cumulative-count register plus the registered CDF sample outputs.
module histeq_cdf_acc
   import histeq_frame_seq_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr_i,
   input  logic                  en_i,
   input  logic [7:0]            level_i,
   input  logic [HIST_CNT_W-1:0] data_i,
   output logic [7:0]            pixel_level_o,
   output logic [HIST_CNT_W-1:0] acc_num_o,
   output logic                  valid_o
);
   logic [HIST_CNT_W-1:0] acc_q, acc_d;
   logic [7:0]            level_q, level_d;
   logic                  valid_q;

   always_comb begin
      acc_d   = clr_i ? '0 : en_i ? sat_add(acc_q, data_i) : acc_q;
      level_d = en_i ? level_i : level_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         level_q <= '0;
         valid_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         level_q <= level_d;
         valid_q <= en_i;
      end
   end

   assign pixel_level_o = level_q;
   assign acc_num_o     = acc_q;
   assign valid_o       = valid_q;
endmodule

// File: rtl/histeq_frame_seq.sv
// histeq_frame_seq: frame sequencer - gates accumulation to whole frames, scans the CDF, clears the RAM, pulses start.
// Optional HISTEQ_PIXCNT_CHECK_EN: compares the frame pixel count with IMG_TOTAL and reports frame_err.
module histeq_frame_seq
   import histeq_frame_seq_pkg::*;
#(
   parameter int unsigned IMG_TOTAL = 480000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  per_img_vsync,
   input  logic                  per_img_href,
   output logic                  hist_acc_en,
   output logic [7:0]            hist_rd_addr,
   input  logic [HIST_CNT_W-1:0] hist_rd_data,
   output logic                  hist_clr_we,
   output logic [7:0]            hist_clr_addr,
   output logic [7:0]            pixel_level,
   output logic [HIST_CNT_W-1:0] pixel_level_acc_num,
   output logic                  pixel_level_valid,
   output logic                  histEQ_start_flag,
   output logic                  frame_skip,
   output logic                  frame_err
);
   state_t     state_q, state_d;
   logic       vs_q, rise, fall, busy, pix_err;
   logic [8:0] c_q, c_d;
   logic [7:0] addr_q, clr_addr_q, cdf_level;
   logic       acc_en_q, clr_we_q, flag_q, skip_q, cdf_en, cdf_clr;

   assign rise = per_img_vsync & ~vs_q;
   assign fall = ~per_img_vsync & vs_q;
   assign busy = state_q inside {ST_SCAN, ST_CLEAR, ST_DONE};

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      case (state_q)
         ST_IDLE:  state_d = rise ? ST_ACCUM : ST_IDLE;
         ST_ACCUM: begin
            state_d = fall ? ST_SCAN : ST_ACCUM;
            c_d     = fall ? '0 : c_q;
         end
         ST_SCAN: begin
            state_d = (c_q == 9'(SCAN_LAST)) ? ST_CLEAR : ST_SCAN;
            c_d     = (c_q == 9'(SCAN_LAST)) ? '0 : c_q + 9'd1;
         end
         ST_CLEAR: begin
            state_d = (c_q == 9'(HIST_BINS - 1)) ? ST_DONE : ST_CLEAR;
            c_d     = (c_q == 9'(HIST_BINS - 1)) ? '0 : c_q + 9'd1;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   // RAM data for address c-1 is on hist_rd_data while c = 1..256, so it lands in the output registers at c = 2..257
   assign cdf_en    = (state_q == ST_SCAN) && (c_q != '0) && (c_q <= 9'(HIST_BINS));
   assign cdf_level = c_q[7:0] - 8'd1;
   assign cdf_clr   = (state_q == ST_ACCUM) && fall;

`ifdef HISTEQ_PIXCNT_CHECK_EN
   logic [HIST_CNT_W-1:0] pix_q, pix_d;
   logic                  err_q;

   always_comb
      pix_d = (state_q == ST_IDLE && rise) ? '0 :
              (state_q == ST_ACCUM && per_img_href && pix_q != '1) ? pix_q + HIST_CNT_W'(1) : pix_q;

   assign pix_err = pix_q != HIST_CNT_W'(IMG_TOTAL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_q <= '0;
         err_q <= 1'b0;
      end else begin
         pix_q <= pix_d;
         err_q <= (state_q == ST_DONE) && pix_err;
      end
   end

   assign frame_err = err_q;
`else
   logic unused_href;
   assign unused_href = per_img_href;
   assign pix_err     = 1'b0;
   assign frame_err   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         vs_q       <= 1'b0;
         c_q        <= '0;
         addr_q     <= '0;
         clr_we_q   <= 1'b0;
         clr_addr_q <= '0;
         acc_en_q   <= 1'b0;
         flag_q     <= 1'b0;
         skip_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         vs_q       <= per_img_vsync;
         c_q        <= c_d;
         addr_q     <= (state_d == ST_SCAN) ? (c_d[8] ? 8'hFF : c_d[7:0]) : addr_q;
         clr_we_q   <= state_d == ST_CLEAR;
         clr_addr_q <= (state_d == ST_CLEAR) ? c_d[7:0] : '0;
         acc_en_q   <= state_d == ST_ACCUM;
         flag_q     <= (state_q == ST_DONE) && !pix_err;
         skip_q     <= rise && busy;
      end
   end

   histeq_cdf_acc u_cdf (
      .clk           (clk),
      .rst_n         (rst_n),
      .clr_i         (cdf_clr),
      .en_i          (cdf_en),
      .level_i       (cdf_level),
      .data_i        (hist_rd_data),
      .pixel_level_o (pixel_level),
      .acc_num_o     (pixel_level_acc_num),
      .valid_o       (pixel_level_valid)
   );

   assign hist_acc_en       = acc_en_q;
   assign hist_rd_addr      = addr_q;
   assign hist_clr_we       = clr_we_q;
   assign hist_clr_addr     = clr_addr_q;
   assign histEQ_start_flag = flag_q;
   assign frame_skip        = skip_q;
endmodule

// File: tb/tb_histeq_frame_seq.sv
// tb_histeq_frame_seq: randomized frames against a behavioural histogram RAM and CDF reference.
module tb_histeq_frame_seq;
   localparam int IMG_T = `ifdef HISTEQ_PIXCNT_CHECK_EN 200 `else 480000 `endif;
   localparam longint CMAX = (1 << 20) - 1;

   logic        clk = 1'b0, rst_n = 1'b0, per_img_vsync = 1'b0, per_img_href = 1'b0;
   logic [7:0]  pix = '0;
   logic        hist_acc_en, hist_clr_we, pixel_level_valid, histEQ_start_flag, frame_skip, frame_err;
   logic [7:0]  hist_rd_addr, hist_clr_addr, pixel_level;
   logic [19:0] hist_rd_data, pixel_level_acc_num;
   logic [19:0] mem[256];
   logic [19:0] pre_bins[256];
   logic        pre_req = 1'b0;
   longint      ref_hist[256];
   longint      exp_cdf[256];
   int          checks = 0, passed = 0;

   histeq_frame_seq #(.IMG_TOTAL(IMG_T)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .per_img_vsync       (per_img_vsync),
      .per_img_href        (per_img_href),
      .hist_acc_en         (hist_acc_en),
      .hist_rd_addr        (hist_rd_addr),
      .hist_rd_data        (hist_rd_data),
      .hist_clr_we         (hist_clr_we),
      .hist_clr_addr       (hist_clr_addr),
      .pixel_level         (pixel_level),
      .pixel_level_acc_num (pixel_level_acc_num),
      .pixel_level_valid   (pixel_level_valid),
      .histEQ_start_flag   (histEQ_start_flag),
      .frame_skip          (frame_skip),
      .frame_err           (frame_err)
   );

   always #5 clk = ~clk;

   // histogram RAM: one-cycle read latency, increments on accepted pixels, zeroed by clear writes
   always @(posedge clk) begin
      if (pre_req) begin
         for (int i = 0; i < 256; i++) mem[i] <= pre_bins[i];
      end else begin
         if (hist_clr_we) mem[hist_clr_addr] <= '0;
         if (hist_acc_en && per_img_href) mem[pix] <= mem[pix] + 20'd1;
      end
      hist_rd_data <= mem[hist_rd_addr];
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [49:0] outs();
      return {hist_acc_en, hist_rd_addr, hist_clr_we, hist_clr_addr, pixel_level,
              pixel_level_acc_num, pixel_level_valid, histEQ_start_flag, frame_skip, frame_err};
   endfunction

   task automatic preload(input int mode);
      for (int i = 0; i < 256; i++) begin
         pre_bins[i] = (mode == 1) ? ((i == 100) ? 20'd480000 : 20'd0) :
                       (mode == 2) ? 20'd1875 :
                       (mode == 3) ? 20'($urandom_range(0, 30000)) : 20'd0;
         ref_hist[i] = longint'(pre_bins[i]);
      end
      pre_req = 1'b1;
      tick();
      pre_req = 1'b0;
   endtask

   task automatic run_frame(input int npix, input int next_rise, input string name);
      int got = 0, first = -1, last = -1, nclr = 0, firstclr = -1, clr_bad = 0;
      int flags = 0, flagcyc = -1, errs = 0, skips = 0, skipcyc = -1, accs = 0, nz = 0;
      bit exp_ok, skip_exp;
      longint s = 0;
      skip_exp = next_rise > 0 && next_rise <= 515;
      exp_ok = `ifdef HISTEQ_PIXCNT_CHECK_EN (npix == IMG_T) `else 1'b1 `endif;
      if (!per_img_vsync) begin
         per_img_vsync = 1'b1;
         tick();
      end
      checks++;
      if (hist_acc_en !== 1'b1) $display("FAIL %s acc_en_on: got %b want 1", name, hist_acc_en); else passed++;
      for (int n = 0; n < npix;) begin
         if ($urandom_range(0, 3) != 0) begin
            per_img_href = 1'b1;
            pix = 8'($urandom);
            ref_hist[pix]++;
            n++;
         end else per_img_href = 1'b0;
         tick();
      end
      per_img_href  = 1'b0;
      per_img_vsync = 1'b0;
      for (int i = 0; i < 256; i++) begin
         s += ref_hist[i];
         exp_cdf[i]  = (s > CMAX) ? CMAX : s;
         ref_hist[i] = 0;
      end
      for (int k = 1; k <= 530; k++) begin
         tick();
         if (k == 1) begin
            checks++;
            if (hist_acc_en !== 1'b0 || hist_rd_addr !== 8'd0)
               $display("FAIL %s scan_entry: got acc_en %b addr %0d want 0 0", name, hist_acc_en, hist_rd_addr);
            else passed++;
         end
         if (pixel_level_valid) begin
            if (first < 0) first = k;
            last = k;
            if (got < 256) begin
               checks++;
               if (pixel_level !== 8'(got) || pixel_level_acc_num !== 20'(exp_cdf[got]))
                  $display("FAIL %s cdf: got level %0d acc %0d want level %0d acc %0d",
                           name, pixel_level, pixel_level_acc_num, got, exp_cdf[got]);
               else passed++;
            end
            got++;
         end
         if (hist_clr_we) begin
            if (firstclr < 0) firstclr = k;
            if (hist_clr_addr !== 8'(nclr)) clr_bad++;
            nclr++;
         end
         if (histEQ_start_flag) begin flags++; flagcyc = k; end
         if (frame_err) errs++;
         if (frame_skip) begin skips++; skipcyc = k; end
         if (k >= 2 && (next_rise == 0 || skip_exp || k <= next_rise) && hist_acc_en) accs++;
         if (k == next_rise) per_img_vsync = 1'b1;
      end
      checks++;
      if (got != 256 || first != 3 || last != 258)
         $display("FAIL %s valid_window: got n=%0d first=%0d last=%0d want 256 3 258", name, got, first, last);
      else passed++;
      checks++;
      if (nclr != 256 || firstclr != 259 || clr_bad != 0)
         $display("FAIL %s clear: got n=%0d first=%0d bad=%0d want 256 259 0", name, nclr, firstclr, clr_bad);
      else passed++;
      checks++;
      if (flags != int'(exp_ok) || (exp_ok && flagcyc != 516))
         $display("FAIL %s start_flag: got n=%0d at %0d want n=%0d at 516", name, flags, flagcyc, exp_ok);
      else passed++;
      checks++;
      if (errs != int'(!exp_ok)) $display("FAIL %s frame_err: got %0d want %0d", name, errs, !exp_ok); else passed++;
      checks++;
      if (skips != int'(skip_exp) || (skip_exp && skipcyc != next_rise + 1))
         $display("FAIL %s frame_skip: got n=%0d at %0d want n=%0d at %0d", name, skips, skipcyc, skip_exp, next_rise + 1);
      else passed++;
      for (int i = 0; i < 256; i++) if (mem[i] != '0) nz++;
      checks++;
      if (nz != 0) $display("FAIL %s ram_cleared: got %0d nonzero bins want 0", name, nz); else passed++;
      if (skip_exp) begin
         for (int k = 0; k < 20; k++) begin
            per_img_href = 1'b1;
            pix = 8'($urandom);
            tick();
            if (hist_acc_en) accs++;
         end
         per_img_href  = 1'b0;
         per_img_vsync = 1'b0;
         repeat (3) tick();
      end
      checks++;
      if (accs != 0) $display("FAIL %s acc_en_gated: got %0d stray cycles want 0", name, accs); else passed++;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if (outs() !== '0) $display("FAIL reset_outputs: got %h want 0", outs()); else passed++;
      rst_n = 1'b1;
      tick();
      checks++;
      if (outs() !== '0) $display("FAIL reset_release: got %h want 0", outs()); else passed++;
   endtask

   task automatic test_level100();
      preload(1);
      run_frame(0, 0, "level100");
   endtask

   task automatic test_uniform();
      preload(2);
      run_frame(0, 0, "uniform");
   endtask

   task automatic test_random_frames();
      preload(0);
      for (int i = 0; i < 3; i++) run_frame($urandom_range(50, 300), 0, "random");
      preload(3);
      run_frame(20, 0, "saturate");
   endtask

   task automatic test_skip();
      preload(0);
      run_frame(30, 100, "skip100");
      run_frame(40, 0, "after_skip");
   endtask

   task automatic test_back_to_back();
      run_frame(10, 515, "rise_at_done");
      run_frame(10, 517, "rise_at_517");
      run_frame(25, 0, "back_to_back");
   endtask

   task automatic test_pixcnt();
      run_frame(199, 0, "pix199");
      run_frame(200, 0, "pix200");
   endtask

   task automatic test_reset_mid();
      preload(3);
      per_img_vsync = 1'b1;
      repeat (3) tick();
      per_img_vsync = 1'b0;
      repeat (51) tick();
      checks++;
      if (pixel_level_valid !== 1'b1 || pixel_level !== 8'd48)
         $display("FAIL mid_scan: got valid %b level %0d want 1 48", pixel_level_valid, pixel_level);
      else passed++;
      rst_n = 1'b0;
      #1;
      checks++;
      if (outs() !== '0) $display("FAIL mid_reset_async: got %h want 0", outs()); else passed++;
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (outs() !== '0) $display("FAIL mid_reset_release: got %h want 0", outs()); else passed++;
      preload(2);
      run_frame(0, 0, "post_reset");
   endtask

   initial begin
      test_reset();
      test_level100();
      test_uniform();
      test_random_frames();
      test_skip();
      test_back_to_back();
      test_pixcnt();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/histeq_frame_seq.md
# histeq_frame_seq

Frame-level sequencer for the luminance histogram-equalisation path. It tracks the input frame on vsync/href and gates histogram accumulation to whole frames. At frame end it scans the 256-bin histogram RAM to produce the cumulative (CDF) stream for the equalisation processor, clears the RAM for the next frame, then pulses the start flag that arms the processor's new mapping.

## Interface
- IMG_TOTAL, 480000, expected pixels per frame (≤ 2^20−1)
- clk  in  1  system clock; one clock for the whole block
- rst_n  in  1  asynchronous, active-low reset
- per_img_vsync  in  1  frame valid, high for the active frame
- per_img_href  in  1  pixel valid within frame
- hist_acc_en  out  1  enables bin increments in the histogram RAM
- hist_rd_addr  out  8  histogram read address
- hist_rd_data  in  20  bin count; valid one cycle after hist_rd_addr
- hist_clr_we  out  1  clear write enable
- hist_clr_addr  out  8  clear write address (write data is always 0)
- pixel_level  out  8  grey level of the CDF sample
- pixel_level_acc_num  out  20  cumulative count up to and including pixel_level
- pixel_level_valid  out  1  CDF sample strobe
- histEQ_start_flag  out  1  one-cycle pulse: new mapping complete
- frame_skip  out  1  one-cycle pulse: frame ignored (sequencer busy)
- frame_err  out  1  one-cycle pulse: pixel count ≠ IMG_TOTAL

## Operation
- Edge detect: vs_d is per_img_vsync registered. rise = vsync & ~vs_d. fall = ~vsync & vs_d.
- FSM states: IDLE (reset), ACCUM, SCAN, CLEAR, DONE.
- IDLE → ACCUM on rise.
- ACCUM: hist_acc_en = 1. Pixel counter counts href-high cycles and saturates at 2^20−1. ACCUM → SCAN on fall.
- SCAN uses a 9-bit counter c = 0..257.
  - hist_rd_addr = c[7:0] while c < 256, else held at 255.
  - At c = 2..257, register the outputs: pixel_level = c−2, acc = acc + hist_rd_data (captured the previous cycle), pixel_level_valid = 1.
  - acc is cleared on entry to SCAN and saturates at 2^20−1.
  - After c = 257, go to CLEAR.
- CLEAR: hist_clr_we = 1 for 256 cycles, hist_clr_addr = 0..255 in order. Then go to DONE.
- DONE: held for 1 cycle. histEQ_start_flag = 1, then IDLE.
- rise while in SCAN, CLEAR or DONE: frame_skip pulses on the cycle after the rise. That frame is not accumulated. The FSM continues and waits in IDLE for the next rise. A skipped frame never reaches ACCUM.
- Zero-length frame (fall one cycle after rise): sequence runs normally with a count of 0.
- A rise coincident with the DONE → IDLE transition counts as a skip.
- All outputs are registered.
- Reset values: every output is 0. State = IDLE, vs_d = 0, acc = 0, counters = 0.
- Reset mid-sequence aborts immediately and the RAM is left uncleared. Software or first-frame results are undefined until one full sequence has completed.

## Timing
- hist_acc_en rises the cycle after rise and falls the cycle after fall.
- First hist_rd_addr = 0 is driven the cycle after fall.
- First pixel_level_valid comes 3 cycles after fall. 256 consecutive valid cycles follow, with no gaps.
- CLEAR starts 259 cycles after fall.
- histEQ_start_flag pulses 516 cycles after fall.
- Minimum vertical blanking for no skip: 517 cycles.

## Configuration
- HISTEQ_PIXCNT_CHECK_EN defined:
  - In DONE, compare the frame pixel count with IMG_TOTAL.
  - On mismatch, frame_err pulses in DONE and histEQ_start_flag is suppressed. SCAN and CLEAR still run.
- Undefined: the pixel counter is not built, frame_err is tied to 0, and histEQ_start_flag always pulses in DONE.

## Structure
- Shared package holds:
  - state encoding constants
  - HIST_BINS = 256
  - HIST_CNT_W = 20
  - SCAN_LAST = 257
- One sub-module, histeq_cdf_acc: the saturating 20-bit accumulator plus the pixel_level/valid output registers.
- The FSM, edge detect, address counters and pixel counter stay in the top module.

## Test plan
- Frame of 480000 href cycles with a histogram model of all pixels at level 100 → acc_num = 0 for levels 0–99 and 480000 for levels 100–255. Start pulses 516 cycles after fall.
- Uniform model, every bin = 1875 → acc_num at level L = 1875·(L+1); level 255 = 480000. Exactly 256 valid pulses.
- Clear check → hist_clr_addr runs 0..255 over 256 consecutive we cycles, beginning 259 cycles after fall.
- Vsync rises 100 cycles after fall → frame_skip pulses, hist_acc_en stays 0 for that frame, and the next frame is processed normally.
- With HISTEQ_PIXCNT_CHECK_EN, a frame of 479999 pixels → frame_err = 1 and no start flag. A 480000-pixel frame → start flag pulses and frame_err = 0.
- rst_n asserted at SCAN c = 50 → all outputs 0 immediately. FSM in IDLE after release, and the next rise enters ACCUM.
